btn_conditioner: RTL and testbench

Parametrised N-channel push-button conditioner sitting between the board buttons and the game controller. Per channel it synchronises, debounces, and produces a stable level, one-cycle press/release pulses, and hold-to-repeat pulses. It also tracks a one-hot "last direction pressed" vector so game logic can steer from a single registered value. It replaces the per-button debounce instances in the top level.

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_conditioner_if.sv | 22 ++
 rtl/btn_channel.sv | 143 ++++++++++++++
 rtl/btn_conditioner.sv | 57 +++++
 tb/tb_btn_conditioner.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
package btn_pkg;

  localparam int MAX_CHANNELS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Isolates the lowest set bit: two's complement clears everything above it.
  function automatic logic [MAX_CHANNELS-1:0] lowest_one_hot(input logic [MAX_CHANNELS-1:0] v);
    return v & (~v + MAX_CHANNELS'(1));
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the board-facing conditioner and the game controller.
interface btn_conditioner_if #(
  parameter int CHANNELS = 4
);
  // "release" is a reserved word, so the release strobe is named release_pulse.
  logic [CHANNELS-1:0] btn_raw;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] rpt;
  logic [CHANNELS-1:0] dir;

  modport master (
    output btn_raw,
    input  level, press, release_pulse, rpt, dir
  );

  modport slave (
    input  btn_raw,
    output level, press, release_pulse, rpt, dir
  );
endinterface

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debounce, edge strobes and hold-to-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rise, fall;

  rpt_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rpt_q, rpt_d;

  assign sync_d = {sync_q[0], btn_raw};

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
        rise    = ~level_q;
        fall    = level_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  assign press_d   = rise;
  assign release_d = fall;

  // NOTE: clocked state uses non-blocking <= only; combinational blocks use =.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Repeat FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rpt_q   <= rpt_d;
    end
  end

  // Repeat FSM: next state. A zero delay parks in DELAY without counting.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (fall) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = DELAY;
            rcnt_d  = '0;
          end
        end
        DELAY: begin
          if (REPEAT_DELAY != 0) begin
            if (rcnt_q == DELAY_LAST) begin
              state_d = REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
        end
        REPEAT: begin
          rcnt_d = (rcnt_q == PERIOD_LAST) ? '0 : rcnt_q + RW'(1);
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // Repeat FSM: outputs. A falling level suppresses any pulse due that cycle.
  always_comb begin
    rpt_d = 1'b0;
    if (!fall) begin
      unique case (state_q)
        IDLE:    rpt_d = rise;
        DELAY:   rpt_d = (REPEAT_DELAY != 0) && (rcnt_q == DELAY_LAST);
        REPEAT:  rpt_d = (rcnt_q == PERIOD_LAST);
        default: rpt_d = 1'b0;
      endcase
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign rpt           = rpt_q;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel button conditioner: per-channel debounce/repeat plus the last-pressed direction register.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  btn_conditioner_if.slave   bus
);

  logic [CHANNELS-1:0]     level_v, press_v, release_v, rpt_v;
  logic [CHANNELS-1:0]     dir_q, dir_d;
  logic [MAX_CHANNELS-1:0] press_wide, onehot_wide;
  logic                    unused_onehot_hi;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (bus.btn_raw[i]),
      .level         (level_v[i]),
      .press         (press_v[i]),
      .release_pulse (release_v[i]),
      .rpt           (rpt_v[i])
    );
  end

  // Simultaneous presses resolve to the lowest channel index.
  always_comb begin
    press_wide                 = '0;
    press_wide[CHANNELS-1:0]   = press_v;
    onehot_wide                = lowest_one_hot(press_wide);
    dir_d                      = (|press_v) ? onehot_wide[CHANNELS-1:0] : dir_q;
  end

  assign unused_onehot_hi = ^onehot_wide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dir_q <= '0;
    else        dir_q <= dir_d;
  end

  assign bus.level         = level_v;
  assign bus.press         = press_v;
  assign bus.release_pulse = release_v;
  assign bus.rpt           = rpt_v;
  assign bus.dir           = dir_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench: two conditioners (repeat enabled / disabled) share one raw input; a behavioural model checks every cycle.
module tb_btn_conditioner;

  localparam int DEB = 8;
  localparam int PER = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  btn_conditioner_if #(.CHANNELS(4)) bus_a ();
  btn_conditioner_if #(.CHANNELS(4)) bus_b ();

  assign bus_a.btn_raw = raw;
  assign bus_b.btn_raw = raw;

  btn_conditioner #(.CHANNELS(4), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(20), .REPEAT_PERIOD(PER))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  btn_conditioner #(.CHANNELS(4), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(0), .REPEAT_PERIOD(PER))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Behavioural model: index 0 = repeat delay 20, index 1 = repeat disabled.
  logic [3:0] pipe[$];
  logic [3:0] m_lvl[2], m_press[2], m_rel[2], m_rpt[2], m_dir[2];
  int         m_run[2][4];
  int         m_age[2][4];

  function automatic int rd_of(input int c);
    return (c == 0) ? 20 : 0;
  endfunction

  function automatic logic rpt_due(input int rd, input int age);
    return (rd > 0) && ((age == rd) || ((age > rd) && ((age - rd) % PER == 0)));
  endfunction

  function automatic logic [3:0] lowest4(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'b0001 << i;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    pipe = '{4'h0, 4'h0};
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = '0; m_press[c] = '0; m_rel[c] = '0; m_rpt[c] = '0; m_dir[c] = '0;
      for (int ch = 0; ch < 4; ch++) begin
        m_run[c][ch] = 0;
        m_age[c][ch] = 0;
      end
    end
  endtask

  // Raw input reaches the debouncer two edges after it is sampled.
  task automatic model_step();
    logic [3:0] s;
    logic       rose, fell;
    s = pipe.pop_front();
    pipe.push_back(raw);
    for (int c = 0; c < 2; c++) begin
      if (m_press[c] != 4'b0) m_dir[c] = lowest4(m_press[c]);
      for (int ch = 0; ch < 4; ch++) begin
        rose = 1'b0;
        fell = 1'b0;
        if (s[ch] != m_lvl[c][ch]) begin
          m_run[c][ch]++;
          if (m_run[c][ch] == DEB) begin
            m_lvl[c][ch] = ~m_lvl[c][ch];
            m_run[c][ch] = 0;
            rose = m_lvl[c][ch];
            fell = ~m_lvl[c][ch];
          end
        end else begin
          m_run[c][ch] = 0;
        end
        m_press[c][ch] = rose;
        m_rel[c][ch]   = fell;
        if (rose) begin
          m_age[c][ch] = 0;
          m_rpt[c][ch] = 1'b1;
        end else if (m_lvl[c][ch]) begin
          m_age[c][ch]++;
          m_rpt[c][ch] = rpt_due(rd_of(c), m_age[c][ch]);
        end else begin
          m_rpt[c][ch] = 1'b0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_n(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed == expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    check("A.level",   bus_a.level,         m_lvl[0]);
    check("A.press",   bus_a.press,         m_press[0]);
    check("A.release", bus_a.release_pulse, m_rel[0]);
    check("A.rpt",     bus_a.rpt,           m_rpt[0]);
    check("A.dir",     bus_a.dir,           m_dir[0]);
    check("B.level",   bus_b.level,         m_lvl[1]);
    check("B.press",   bus_b.press,         m_press[1]);
    check("B.release", bus_b.release_pulse, m_rel[1]);
    check("B.rpt",     bus_b.rpt,           m_rpt[1]);
    check("B.dir",     bus_b.dir,           m_dir[1]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".A.level"},   bus_a.level,         4'b0);
    check({tag, ".A.press"},   bus_a.press,         4'b0);
    check({tag, ".A.release"}, bus_a.release_pulse, 4'b0);
    check({tag, ".A.rpt"},     bus_a.rpt,           4'b0);
    check({tag, ".A.dir"},     bus_a.dir,           4'b0);
    check({tag, ".B.level"},   bus_b.level,         4'b0);
    check({tag, ".B.rpt"},     bus_b.rpt,           4'b0);
    check({tag, ".B.dir"},     bus_b.dir,           4'b0);
  endtask

  // One clock: advance the model on the edge, compare 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
    check_all();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sticky;
    logic [3:0] exp_rpt;
    int         found_at;
    int         b_rpts, b_mis;

    raw   = '0;
    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b1;

    // Clean press on channel 1.
    raw[1] = 1'b1;
    repeat (9) tick();
    check("press1.early_level", bus_a.level, 4'b0000);
    tick();
    check("press1.level", bus_a.level, 4'b0010);
    check("press1.press", bus_a.press, 4'b0010);
    check("press1.rptA",  bus_a.rpt,   4'b0010);
    check("press1.rptB",  bus_b.rpt,   4'b0010);
    tick();
    check("press1.width", bus_a.press, 4'b0000);
    check("press1.dir",   bus_a.dir,   4'b0010);
    raw[1] = 1'b0;
    repeat (9) tick();
    check("rel1.early", bus_a.release_pulse, 4'b0000);
    tick();
    check("rel1.release", bus_a.release_pulse, 4'b0010);
    check("rel1.level",   bus_a.level,         4'b0000);
    check("rel1.dir_kept", bus_a.dir,          4'b0010);
    repeat (5) tick();

    // Bounce rejection on channel 0.
    sticky = '0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) raw[0] = ~raw[0];
      tick();
      sticky |= bus_a.level | bus_a.press | bus_a.rpt | bus_b.level | bus_b.press | bus_b.rpt;
    end
    raw[0] = 1'b0;
    repeat (12) begin
      tick();
      sticky |= bus_a.level | bus_a.press | bus_a.rpt;
    end
    check("bounce.quiet", sticky, 4'b0000);

    // Auto-repeat on channel 2, held 60 cycles after the level rises.
    raw[2] = 1'b1;
    repeat (9) tick();
    for (int k = 0; k < 60; k++) begin
      tick();
      exp_rpt = (k == 0 || (k >= 20 && (k - 20) % PER == 0)) ? 4'b0100 : 4'b0000;
      check("repeat.A", bus_a.rpt, exp_rpt);
      check("repeat.B", bus_b.rpt, (k == 0) ? 4'b0100 : 4'b0000);
      if (k == 1) check("repeat.dir", bus_a.dir, 4'b0100);
    end
    raw[2] = 1'b0;
    found_at = -1;
    for (int i = 1; i <= 20 && found_at < 0; i++) begin
      tick();
      if (bus_a.release_pulse[2]) found_at = i;
    end
    check_n("repeat.release_latency", found_at, 10);
    sticky = '0;
    repeat (30) begin
      tick();
      sticky |= bus_a.rpt;
    end
    check("repeat.after_release", sticky, 4'b0000);

    // Simultaneous press on channels 3 and 1.
    raw[3] = 1'b1;
    raw[1] = 1'b1;
    repeat (10) tick();
    check("simul.pressA", bus_a.press, 4'b1010);
    check("simul.pressB", bus_b.press, 4'b1010);
    tick();
    check("simul.width", bus_a.press, 4'b0000);
    check("simul.dir",   bus_a.dir,   4'b0010);
    raw = '0;
    repeat (12) tick();
    raw[3] = 1'b1;
    repeat (10) tick();
    check("ch3.press", bus_a.press, 4'b1000);
    tick();
    check("ch3.dir", bus_a.dir, 4'b1000);
    raw = '0;
    repeat (12) tick();

    // Reset during REPEAT with channel 0 held, then fresh press afterwards.
    raw[0] = 1'b1;
    repeat (10) tick();
    check("pre_reset.press", bus_a.press, 4'b0001);
    repeat (25) tick();
    #3;
    reset = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    b_rpts = 0;
    b_mis  = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 9)  check("postreset.early", bus_a.press, 4'b0000);
      if (i == 10) begin
        check("postreset.pressA", bus_a.press, 4'b0001);
        check("postreset.pressB", bus_b.press, 4'b0001);
      end
      if (bus_b.rpt[0]) b_rpts++;
      if (bus_b.rpt[0] != bus_b.press[0]) b_mis++;
    end
    check_n("norepeat.count", b_rpts, 1);
    check_n("norepeat.coincide", b_mis, 0);
    raw = '0;
    repeat (12) tick();

    // Randomised phase: alternate slow (clean) and fast (bouncy) blocks, one async reset mid-way.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        #3;
        reset = 1'b0;
        #1;
        check_zero("rand.reset");
        model_reset();
        tick();
        reset = 1'b1;
      end
      for (int ch = 0; ch < 4; ch++) begin
        if (((i / 200) % 2 == 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0))
          raw[ch] = ~raw[ch];
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
